// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - requester, ALU and response signal bundle for alu_share_ctrl
interface alu_share_ctrl_if #(
  parameter int N = 4
);
  logic       a_req_valid;
  logic       a_req_ready;
  logic [4:0] a_op;
  logic [N:0] a_x;
  logic [N:0] a_y;
  logic       b_req_valid;
  logic       b_req_ready;
  logic [4:0] b_op;
  logic [N:0] b_x;
  logic [N:0] b_y;
  logic [4:0] alu_select;
  logic [N:0] alu_x;
  logic [N:0] alu_y;
  logic [N:0] alu_result;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [N:0] resp_result;
  logic       resp_err;

  modport master (
    output a_req_valid, a_op, a_x, a_y,
    output b_req_valid, b_op, b_x, b_y,
    output alu_result, resp_ready,
    input  a_req_ready, b_req_ready,
    input  alu_select, alu_x, alu_y,
    input  resp_valid, resp_id, resp_result, resp_err
  );

  modport slave (
    input  a_req_valid, a_op, a_x, a_y,
    input  b_req_valid, b_op, b_x, b_y,
    input  alu_result, resp_ready,
    output a_req_ready, b_req_ready,
    output alu_select, alu_x, alu_y,
    output resp_valid, resp_id, resp_result, resp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one ALU between requesters A and B
module alu_share_ctrl #(
  parameter int N          = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [4:0] sel_q, sel_nxt;
  logic [N:0] x_q, x_nxt;
  logic [N:0] y_q, y_nxt;
  logic [N:0] res_q, res_nxt;
  logic       id_q, id_nxt;
  logic       err_q, err_nxt;

  logic       any_req;
  logic       grant;
  logic       accept;
  logic [4:0] g_op;
  logic [N:0] g_x;
  logic [N:0] g_y;
  logic [3:0] lat_m1;

  // On a tie the requester not served last wins; last_grant resets to B so A wins first.
  always_comb begin
    any_req = bus.a_req_valid | bus.b_req_valid;
    if (bus.a_req_valid && !bus.b_req_valid) begin
      grant = 1'b0;
    end else if (bus.b_req_valid && !bus.a_req_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_grant;
    end
  end

  assign bus.a_req_ready = !rst && (state == IDLE) && any_req && !grant;
  assign bus.b_req_ready = !rst && (state == IDLE) && any_req && grant;
  assign accept          = bus.a_req_ready | bus.b_req_ready;

  assign g_op = grant ? bus.b_op : bus.a_op;
  assign g_x  = grant ? bus.b_x  : bus.a_x;
  assign g_y  = grant ? bus.b_y  : bus.a_y;

  always_comb begin
    case (g_op)
      5'd4:    lat_m1 = 4'(MUL_CYCLES - 1);
      5'd5:    lat_m1 = 4'(DIV_CYCLES - 1);
      default: lat_m1 = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    sel_nxt        = sel_q;
    x_nxt          = x_q;
    y_nxt          = y_q;
    res_nxt        = res_q;
    id_nxt         = id_q;
    err_nxt        = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          sel_nxt        = g_op;
          x_nxt          = g_x;
          y_nxt          = g_y;
          id_nxt         = grant;
          last_grant_nxt = grant;
          if (g_op <= 5'd10) begin
            cnt_nxt   = lat_m1;
            state_nxt = EXEC;
          end else begin
            // Unknown op codes never touch the ALU; they answer with an error at once.
            res_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          res_nxt   = bus.alu_result;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      sel_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      res_q      <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      sel_q      <= sel_nxt;
      x_q        <= x_nxt;
      y_q        <= y_nxt;
      res_q      <= res_nxt;
      id_q       <= id_nxt;
      err_q      <= err_nxt;
    end
  end

  assign bus.alu_select  = sel_q;
  assign bus.alu_x       = x_q;
  assign bus.alu_y       = y_q;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = id_q;
  assign bus.resp_result = res_q;
  assign bus.resp_err    = err_q;

endmodule
